// File: rtl/zint_multi_pkg.sv
// Shared definitions for the multi-source Z80 interrupt generator:
// FSM state encodings, default vector base and small helpers.
package zint_multi_pkg;

   // INTA handshake FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [7:0] VEC_BASE_DEF = 8'hF0;
   // Value on the vector port whenever nothing is being driven
   localparam logic [7:0] VEC_NONE     = 8'hFF;

   // Counter must be able to hold PULSE_LEN itself (32 -> 6 bits)
   function automatic int cnt_width(input int pulse_len);
      return $clog2(pulse_len + 1);
   endfunction

   // IM2 vector: base OR'ed with the source index shifted left by one
   function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
      return base | {4'b0000, idx, 1'b0};
   endfunction

endpackage

// File: rtl/zint_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt requests.
module zint_prio_enc #(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] i_req,
   output logic [2:0]      o_idx,
   output logic            o_any
);

   // Scan from the top down so the lowest set index wins
   always_comb begin
      o_idx = 3'd0;
      o_any = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = 3'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/zint_multi.sv
// Multi-source Z80 INT generator: per-source pending latches and enables,
// optional auto-timeout per source, INTA synchroniser and IM2 vector FSM.
module zint_multi
   import zint_multi_pkg::*;
#(
   parameter int         NSRC      = 4,
   parameter int         PULSE_LEN = 32,
   parameter logic [7:0] TO_MASK   = 8'h01,
   parameter logic [7:0] VEC_BASE  = VEC_BASE_DEF
) (
   input  logic            i_fclk,
   input  logic            i_rst_n,
   input  logic            i_zpos,
   input  logic [NSRC-1:0] i_src_stb,
   input  logic            i_m1_n,
   input  logic            i_iorq_n,
   input  logic            i_en_we,
   input  logic [NSRC-1:0] i_en_din,
   output logic            o_int_n,
   output logic [7:0]      o_vec_dout,
   output logic            o_vec_ena,
   output logic [NSRC-1:0] o_pending,
   output logic [NSRC-1:0] o_enable
);

   localparam int CW = cnt_width(PULSE_LEN);

   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_en;
   logic            r_int_n;
   logic [7:0]      r_vec_dout;
   logic            r_vec_ena;
   logic [1:0]      r_state;
   logic [2:0]      r_idx;
   logic            r_any;
   logic            r_inta_s1;
   logic            r_inta_s;
   logic            r_inta_d;

   logic [NSRC-1:0] w_to_clr;
   logic [NSRC-1:0] w_ack_clr;
   logic [NSRC-1:0] w_pend_nxt;
   logic [NSRC-1:0] w_en_nxt;
   logic [2:0]      w_idx;
   logic            w_any;
   logic            w_inta_rise;

   // Per-source timeout: zeroed on set, counts zpos while pending and drops
   // the latch on the PULSE_LEN-th strobe (frame INT style pulse)
   for (genvar gi = 0; gi < NSRC; gi++) begin : g_to
      if (TO_MASK[gi]) begin : g_cnt
         logic [CW-1:0] r_cnt;
         logic          w_hit;

         assign w_hit        = r_pend[gi] & i_zpos & (r_cnt == CW'(PULSE_LEN - 1));
         assign w_to_clr[gi] = w_hit;

         // Timeout counter; a re-strobe restarts it
         always_ff @(posedge i_fclk or negedge i_rst_n) begin
            if (!i_rst_n)                     r_cnt <= '0;
            else if (i_src_stb[gi] | w_hit)   r_cnt <= '0;
            else if (r_pend[gi] & i_zpos)     r_cnt <= r_cnt + 1'b1;
         end
      end else begin : g_nocnt
         assign w_to_clr[gi] = 1'b0;
      end
   end

   // Acknowledged source is cleared in the single ACK cycle
   assign w_ack_clr  = (r_state == ST_ACK && r_any) ? (NSRC'(1) << r_idx) : '0;
   // Set beats any clear arriving in the same cycle
   assign w_pend_nxt = i_src_stb | (r_pend & ~(w_to_clr | w_ack_clr));
   assign w_en_nxt   = i_en_we ? i_en_din : r_en;

   zint_prio_enc #(.NSRC(NSRC)) u_prio (
      .i_req (r_pend & r_en),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Pending/enable registers; int_n is built from next-state values so a
   // strobe or enable write shows on int_n exactly one cycle later
   always_ff @(posedge i_fclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend  <= '0;
         r_en    <= '0;
         r_int_n <= 1'b1;
      end else begin
         r_pend  <= w_pend_nxt;
         r_en    <= w_en_nxt;
         r_int_n <= ~|(w_pend_nxt & w_en_nxt);
      end
   end

   // Two-flop synchroniser for the asynchronous INTA cycle, plus edge history
   always_ff @(posedge i_fclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inta_s1 <= 1'b0;
         r_inta_s  <= 1'b0;
         r_inta_d  <= 1'b0;
      end else begin
         r_inta_s1 <= ~i_m1_n & ~i_iorq_n;
         r_inta_s  <= r_inta_s1;
         r_inta_d  <= r_inta_s;
      end
   end

   assign w_inta_rise = r_inta_s & ~r_inta_d;

   // INTA FSM: latch the winner on INTA rise, drive its vector until INTA ends
   always_ff @(posedge i_fclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= 3'd0;
         r_any      <= 1'b0;
         r_vec_ena  <= 1'b0;
         r_vec_dout <= VEC_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_inta_rise) begin
                  r_state    <= ST_ACK;
                  r_idx      <= w_idx;
                  r_any      <= w_any;
                  // Spurious INTA leaves the bus undriven
                  r_vec_ena  <= w_any;
                  r_vec_dout <= w_any ? vec_of(VEC_BASE, w_idx) : VEC_NONE;
               end
            end
            ST_ACK: begin
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!r_inta_s) begin
                  r_state    <= ST_IDLE;
                  r_vec_ena  <= 1'b0;
                  r_vec_dout <= VEC_NONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_int_n    = r_int_n;
   assign o_vec_dout = r_vec_dout;
   assign o_vec_ena  = r_vec_ena;
   assign o_pending  = r_pend;
   assign o_enable   = r_en;

endmodule

// File: tb/tb_zint_multi.sv
// Scoreboard bench for zint_multi: a cycle-level reference model of the
// pending/enable/timeout rules drives expectations; vectors are queued at
// INTA time and checked by an independent monitor.
module tb_zint_multi;

   localparam int         NSRC = 4;
   localparam int         PL   = 32;
   localparam logic [3:0] TOM  = 4'b0001;

   logic       fclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       zpos = 1'b0;
   logic [3:0] src_stb = '0;
   logic       m1_n = 1'b1;
   logic       iorq_n = 1'b1;
   logic       en_we = 1'b0;
   logic [3:0] en_din = '0;
   logic       int_n;
   logic [7:0] vec_dout;
   logic       vec_ena;
   logic [3:0] pending;
   logic [3:0] enable;

   always #5 fclk = ~fclk;

   zint_multi dut (
      .i_fclk    (fclk),
      .i_rst_n   (rst_n),
      .i_zpos    (zpos),
      .i_src_stb (src_stb),
      .i_m1_n    (m1_n),
      .i_iorq_n  (iorq_n),
      .i_en_we   (en_we),
      .i_en_din  (en_din),
      .o_int_n   (int_n),
      .o_vec_dout(vec_dout),
      .o_vec_ena (vec_ena),
      .o_pending (pending),
      .o_enable  (enable)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   logic [3:0] m_pend = '0;
   logic [3:0] m_en = '0;
   int         zc[NSRC];
   bit         inta_on = 0;
   int         age = 0;
   bit         m_any = 0;
   int         m_idx = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance the reference model with the inputs seen at the edge
   task automatic step();
      logic [3:0] clr;
      @(posedge fclk);
      clr = '0;
      if (inta_on) begin
         // INTA passes two sync flops, is seen rising on the third edge,
         // and the winner is cleared on the fourth
         if (age == 2) begin
            m_any = 0;
            m_idx = 0;
            for (int i = NSRC - 1; i >= 0; i--)
               if (m_pend[i] & m_en[i]) begin m_any = 1; m_idx = i; end
            if (m_any) exp_q.push_back(8'hF0 | 8'(m_idx * 2));
         end
         if (age == 3 && m_any) clr[m_idx] = 1'b1;
         age++;
      end else begin
         age = 0;
      end
      for (int i = 0; i < NSRC; i++) begin
         if (TOM[i] && zpos && m_pend[i]) begin
            zc[i]++;
            if (zc[i] == PL) clr[i] = 1'b1;
         end
      end
      for (int i = 0; i < NSRC; i++) begin
         if (src_stb[i]) begin m_pend[i] = 1'b1; zc[i] = 0; end
         else if (clr[i]) m_pend[i] = 1'b0;
      end
      if (en_we) m_en = en_din;
      #1;
      chk("pending", pending, m_pend);
      chk("enable", enable, m_en);
      chk("int_n", int_n, ~|(m_pend & m_en));
   endtask

   task automatic cyc(input logic [3:0] stb, input logic zp, input logic we, input logic [3:0] din);
      src_stb = stb; zpos = zp; en_we = we; en_din = din;
      step();
      src_stb = '0; zpos = 1'b0; en_we = 1'b0; en_din = '0;
   endtask

   task automatic rstep(input bit rnd, input logic [3:0] extra);
      logic [3:0] s;
      s = extra;
      if (rnd) begin
         for (int i = 0; i < NSRC; i++) if ($urandom_range(7) == 0) s[i] = 1'b1;
         cyc(s, 1'($urandom_range(1)), ($urandom_range(15) == 0), 4'($urandom_range(15)));
      end else begin
         cyc(s, 1'b0, 1'b0, 4'h0);
      end
   endtask

   // Full INTA cycle; ack_stb is driven in the ACK cycle
   task automatic inta(input int hold, input logic [3:0] ack_stb, input bit rnd);
      m1_n = 1'b0; iorq_n = 1'b0; inta_on = 1;
      for (int k = 0; k < 3; k++) rstep(rnd, 4'h0);
      chk("vec_ena_ack", vec_ena, m_any);
      rstep(rnd, ack_stb);
      for (int k = 1; k < hold; k++) rstep(rnd, 4'h0);
      m1_n = 1'b1; iorq_n = 1'b1; inta_on = 0;
      for (int k = 0; k < 3; k++) rstep(rnd, 4'h0);
      chk("vec_ena_release", vec_ena, 1'b0);
   endtask

   // Monitor: pop the expected vector whenever the DUT starts driving one
   initial begin
      logic       pe;
      logic [7:0] e;
      pe = 1'b0;
      e  = 8'hFF;
      forever begin
         @(posedge fclk);
         #2;
         if (vec_ena && !pe) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL vec_unexpected: got %0h expected no vector", vec_dout);
            end else begin
               e = exp_q.pop_front();
               chk("vec_dout", vec_dout, e);
            end
         end else if (vec_ena) begin
            chk("vec_hold", vec_dout, e);
         end
         pe = vec_ena;
      end
   end

   initial begin
      int n;
      for (int i = 0; i < NSRC; i++) zc[i] = 0;

      // Reset values
      repeat (2) @(posedge fclk);
      #1;
      chk("rst_int_n", int_n, 1'b1);
      chk("rst_vec_ena", vec_ena, 1'b0);
      chk("rst_vec_dout", vec_dout, 8'hFF);
      chk("rst_pending", pending, 4'h0);
      chk("rst_enable", enable, 4'h0);
      @(negedge fclk);
      rst_n = 1'b1;

      // 1: frame source times out after exactly PL zpos strobes
      cyc(4'h0, 1'b0, 1'b1, 4'b0001);
      cyc(4'b0001, 1'b0, 1'b0, 4'h0);
      chk("t1_int_low", int_n, 1'b0);
      n = 0;
      while (int_n == 1'b0 && n < 40) begin
         cyc(4'h0, 1'b1, 1'b0, 4'h0);
         cyc(4'h0, 1'b0, 1'b0, 4'h0);
         n++;
      end
      chk("t1_zpos_count", n, PL);
      chk("t1_pending0", pending[0], 1'b0);

      // 2: two sources, served lowest index first
      cyc(4'h0, 1'b0, 1'b1, 4'b0110);
      cyc(4'b0110, 1'b0, 1'b0, 4'h0);
      inta(2, 4'h0, 0);
      chk("t2_pending", pending, 4'b0100);
      chk("t2_int_low", int_n, 1'b0);
      inta(2, 4'h0, 0);
      chk("t2_int_high", int_n, 1'b1);

      // 3: re-strobe in the ACK cycle keeps the source pending
      cyc(4'b0010, 1'b0, 1'b0, 4'h0);
      inta(3, 4'b0010, 0);
      chk("t3_pending1", pending[1], 1'b1);
      chk("t3_int_low", int_n, 1'b0);
      inta(2, 4'h0, 0);

      // 4: spurious INTA (pending but disabled)
      cyc(4'b1000, 1'b0, 1'b0, 4'h0);
      cyc(4'h0, 1'b0, 1'b1, 4'h0);
      inta(2, 4'h0, 0);
      chk("t4_pending3", pending[3], 1'b1);

      // 6: enabling an already-pending source pulls int_n a cycle later
      cyc(4'h0, 1'b0, 1'b1, 4'b1000);
      chk("t6_int_low", int_n, 1'b0);
      inta(2, 4'h0, 0);

      // 5: reset during HOLD releases outputs without a clock edge
      cyc(4'b0100, 1'b0, 1'b1, 4'b0100);
      m1_n = 1'b0; iorq_n = 1'b0; inta_on = 1;
      for (int k = 0; k < 5; k++) rstep(0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_vec_ena", vec_ena, 1'b0);
      chk("t5_int_n", int_n, 1'b1);
      chk("t5_pending", pending, 4'h0);
      chk("t5_enable", enable, 4'h0);
      m1_n = 1'b1; iorq_n = 1'b1; inta_on = 0; age = 0;
      m_pend = '0; m_en = '0;
      for (int i = 0; i < NSRC; i++) zc[i] = 0;
      @(negedge fclk);
      rst_n = 1'b1;
      step();

      // Randomised traffic
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(10, 5);
         for (int k = 0; k < n; k++) rstep(1, 4'h0);
         inta($urandom_range(5, 1), 4'h0, 1);
      end

      repeat (3) @(posedge fclk);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
